// File: rtl/cp0_reg_pkg.sv
// Shared CP0 definitions: register numbers, Status/Cause bit positions, ExcCodes
// and the helpers that pack Status and Cause into their architectural layout.
package cp0_reg_pkg;

   localparam int DATA_W = 32;

   localparam logic [4:0] CP0_BADVADDR = 5'd8;
   localparam logic [4:0] CP0_COUNT    = 5'd9;
   localparam logic [4:0] CP0_COMPARE  = 5'd11;
   localparam logic [4:0] CP0_STATUS   = 5'd12;
   localparam logic [4:0] CP0_CAUSE    = 5'd13;
   localparam logic [4:0] CP0_EPC      = 5'd14;

   localparam int STATUS_BEV = 22;
   localparam int STATUS_EXL = 1;
   localparam int STATUS_IE  = 0;
   localparam int CAUSE_BD   = 31;
   localparam int CAUSE_TI   = 30;

   localparam logic [4:0] EXC_INT  = 5'h00;
   localparam logic [4:0] EXC_ADEL = 5'h04;
   localparam logic [4:0] EXC_ADES = 5'h05;
   localparam logic [4:0] EXC_SYS  = 5'h08;
   localparam logic [4:0] EXC_BP   = 5'h09;
   localparam logic [4:0] EXC_RI   = 5'h0a;
   localparam logic [4:0] EXC_OV   = 5'h0c;

   function automatic logic [DATA_W-1:0] pack_status(input logic [7:0] im,
                                                     input logic exl,
                                                     input logic ie);
      logic [DATA_W-1:0] s;
      s             = '0;
      s[STATUS_BEV] = 1'b1;
      s[15:8]       = im;
      s[STATUS_EXL] = exl;
      s[STATUS_IE]  = ie;
      return s;
   endfunction

   function automatic logic [DATA_W-1:0] pack_cause(input logic bd,
                                                    input logic ti,
                                                    input logic [7:0] ip,
                                                    input logic [4:0] exccode);
      logic [DATA_W-1:0] c;
      c           = '0;
      c[CAUSE_BD] = bd;
      c[CAUSE_TI] = ti;
      c[15:8]     = ip;
      c[6:2]      = exccode;
      return c;
   endfunction

endpackage

// File: rtl/cp0_reg_timer.sv
// Count/Compare timer: Count advances every second cycle, TI latches on a
// non-zero Compare match and is cleared by any MTC0 to Compare.
module cp0_timer
   import cp0_reg_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              w_en,
   input  logic [4:0]        w_addr,
   input  logic [DATA_W-1:0] w_data,
   output logic              ti,
   output logic [DATA_W-1:0] count,
   output logic [DATA_W-1:0] compare
);

   logic tick;
   logic wr_count;
   logic wr_compare;

   assign wr_count   = w_en && (w_addr == CP0_COUNT);
   assign wr_compare = w_en && (w_addr == CP0_COMPARE);

   always_ff @(posedge clk) begin
      if (rst) begin
         tick    <= 1'b0;
         count   <= '0;
         compare <= '0;
         ti      <= 1'b0;
      end else begin
         tick <= ~tick;
         if (wr_count)
            count <= w_data;
         else if (tick)
            count <= count + 32'd1;
         if (wr_compare)
            compare <= w_data;
         // A Compare write acknowledges the timer even if it matches this cycle.
         if (wr_compare)
            ti <= 1'b0;
         else if ((count == compare) && (compare != '0))
            ti <= 1'b1;
      end
   end

endmodule

// File: rtl/cp0_reg.sv
// CP0 register file: BadVAddr, Count, Compare, Status, Cause, EPC with
// exception/ERET commit handling and interrupt request generation.
module cp0_reg
   import cp0_reg_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        cp0_w_en,
   input  logic [4:0]  cp0_w_addr,
   input  logic [31:0] cp0_w_data,
   input  logic [4:0]  cp0_r_addr,
   output logic [31:0] cp0_r_data,
   input  logic [5:0]  ext_int,
   input  logic        exc_valid,
   input  logic [4:0]  exc_code,
   input  logic [31:0] exc_pc,
   input  logic        exc_bd,
   input  logic [31:0] exc_badvaddr,
   input  logic        exc_badvaddr_we,
   input  logic        eret,
   output logic [31:0] epc_out,
   output logic        int_req
);

   logic [7:0]        status_im;
   logic              status_exl;
   logic              status_ie;
   logic              cause_bd;
   logic [4:0]        cause_exccode;
   logic [1:0]        cause_ip_sw;
   logic [5:0]        ext_int_q;
   logic [DATA_W-1:0] epc;
   logic [DATA_W-1:0] badvaddr;
   logic              ti;
   logic [DATA_W-1:0] count;
   logic [DATA_W-1:0] compare;
   logic [7:0]        cause_ip;

   cp0_timer u_timer (
      .clk     (clk),
      .rst     (rst),
      .w_en    (cp0_w_en),
      .w_addr  (cp0_w_addr),
      .w_data  (cp0_w_data),
      .ti      (ti),
      .count   (count),
      .compare (compare)
   );

   // Timer interrupt shares the IP7 line with the highest external input.
   assign cause_ip = {ext_int_q[5] | ti, ext_int_q[4:0], cause_ip_sw};

   always_ff @(posedge clk) begin
      if (rst) begin
         status_im     <= '0;
         status_exl    <= 1'b0;
         status_ie     <= 1'b0;
         cause_bd      <= 1'b0;
         cause_exccode <= '0;
         cause_ip_sw   <= '0;
         ext_int_q     <= '0;
         epc           <= '0;
         badvaddr      <= '0;
      end else begin
         ext_int_q <= ext_int;
         if (exc_valid && exc_badvaddr_we)
            badvaddr <= exc_badvaddr;
         if (exc_valid) begin
            status_exl    <= 1'b1;
            cause_exccode <= exc_code;
            // A nested exception keeps the original return point.
            if (!status_exl) begin
               epc      <= exc_bd ? (exc_pc - 32'd4) : exc_pc;
               cause_bd <= exc_bd;
            end
         end else if (eret) begin
            status_exl <= 1'b0;
         end else if (cp0_w_en) begin
            case (cp0_w_addr)
               CP0_STATUS: begin
                  status_im  <= cp0_w_data[15:8];
                  status_exl <= cp0_w_data[STATUS_EXL];
                  status_ie  <= cp0_w_data[STATUS_IE];
               end
               CP0_CAUSE: cause_ip_sw <= cp0_w_data[9:8];
               CP0_EPC:   epc         <= cp0_w_data;
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      cp0_r_data = '0;
      case (cp0_r_addr)
         CP0_BADVADDR: cp0_r_data = badvaddr;
         CP0_COUNT:    cp0_r_data = count;
         CP0_COMPARE:  cp0_r_data = compare;
         CP0_STATUS:   cp0_r_data = pack_status(status_im, status_exl, status_ie);
         CP0_CAUSE:    cp0_r_data = pack_cause(cause_bd, ti, cause_ip, cause_exccode);
         CP0_EPC:      cp0_r_data = epc;
         default:      cp0_r_data = '0;
      endcase
   end

   assign epc_out = epc;
   assign int_req = ~rst & status_ie & ~status_exl & (|(status_im & cause_ip));

endmodule

// File: tb/tb_cp0_reg.sv
// Directed self-checking bench for cp0_reg with hand-computed expectations.
module tb_cp0_reg;

   logic        clk;
   logic        rst;
   logic        cp0_w_en;
   logic [4:0]  cp0_w_addr;
   logic [31:0] cp0_w_data;
   logic [4:0]  cp0_r_addr;
   logic [31:0] cp0_r_data;
   logic [5:0]  ext_int;
   logic        exc_valid;
   logic [4:0]  exc_code;
   logic [31:0] exc_pc;
   logic        exc_bd;
   logic [31:0] exc_badvaddr;
   logic        exc_badvaddr_we;
   logic        eret;
   logic [31:0] epc_out;
   logic        int_req;

   int checks;
   int failures;

   cp0_reg dut (
      .clk             (clk),
      .rst             (rst),
      .cp0_w_en        (cp0_w_en),
      .cp0_w_addr      (cp0_w_addr),
      .cp0_w_data      (cp0_w_data),
      .cp0_r_addr      (cp0_r_addr),
      .cp0_r_data      (cp0_r_data),
      .ext_int         (ext_int),
      .exc_valid       (exc_valid),
      .exc_code        (exc_code),
      .exc_pc          (exc_pc),
      .exc_bd          (exc_bd),
      .exc_badvaddr    (exc_badvaddr),
      .exc_badvaddr_we (exc_badvaddr_we),
      .eret            (eret),
      .epc_out         (epc_out),
      .int_req         (int_req)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic rd_check(input string tag, input logic [4:0] addr, input logic [31:0] exp);
      cp0_r_addr = addr;
      #1;
      check(tag, cp0_r_data, exp);
   endtask

   task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
      cp0_w_en   = 1'b1;
      cp0_w_addr = addr;
      cp0_w_data = data;
      cycle();
      cp0_w_en   = 1'b0;
   endtask

   task automatic set_exc(input logic [31:0] pc, input logic bd, input logic [4:0] code,
                          input logic [31:0] bva, input logic bva_we);
      exc_valid       = 1'b1;
      exc_pc          = pc;
      exc_bd          = bd;
      exc_code        = code;
      exc_badvaddr    = bva;
      exc_badvaddr_we = bva_we;
   endtask

   task automatic clr_exc();
      exc_valid       = 1'b0;
      exc_badvaddr_we = 1'b0;
   endtask

   initial begin
      int n;
      checks = 0;
      failures = 0;
      rst = 1'b1;
      cp0_w_en = 1'b0; cp0_w_addr = '0; cp0_w_data = '0; cp0_r_addr = '0;
      ext_int = '0; eret = 1'b0;
      exc_valid = 1'b0; exc_code = '0; exc_pc = '0; exc_bd = 1'b0;
      exc_badvaddr = '0; exc_badvaddr_we = 1'b0;

      // Reset, with interrupt-enabling state requested but overridden.
      ext_int = 6'h3f;
      cycle(); cycle(); cycle();
      check("int_req_in_rst", {31'd0, int_req}, 32'd0);
      ext_int = '0;
      cycle();
      rst = 1'b0;
      rd_check("rst_status", 5'd12, 32'h0040_0000);
      rd_check("rst_cause", 5'd13, 32'h0);
      rd_check("rst_count", 5'd9, 32'h0);
      rd_check("rst_unimpl3", 5'd3, 32'h0);
      check("rst_epc_out", epc_out, 32'h0);

      // Writes to an unimplemented register are ignored.
      mtc0(5'd3, 32'hFFFF_FFFF);
      rd_check("unimpl_write", 5'd3, 32'h0);

      // Read data shows registered state, not the same-cycle write.
      mtc0(5'd14, 32'h1111_1110);
      cp0_w_en = 1'b1; cp0_w_addr = 5'd14; cp0_w_data = 32'h2222_2220;
      rd_check("epc_no_bypass", 5'd14, 32'h1111_1110);
      check("epc_out_no_bypass", epc_out, 32'h1111_1110);
      cycle();
      cp0_w_en = 1'b0;
      check("epc_out_after", epc_out, 32'h2222_2220);

      // Count wrap.
      mtc0(5'd9, 32'hFFFF_FFFF);
      rd_check("count_loaded", 5'd9, 32'hFFFF_FFFF);
      cycle(); cycle();
      rd_check("count_wrap", 5'd9, 32'h0);

      // Only IP[9:8] of Cause are software-writable.
      mtc0(5'd13, 32'hFFFF_FFFF);
      rd_check("cause_sw_mask", 5'd13, 32'h0000_0300);
      mtc0(5'd13, 32'h0);

      // Timer interrupt.
      mtc0(5'd12, 32'h0000_8001);
      rd_check("status_im7_ie", 5'd12, 32'h0040_8001);
      mtc0(5'd9, 32'h0000_0100);
      mtc0(5'd11, 32'd5);
      mtc0(5'd9, 32'd0);
      cp0_r_addr = 5'd13;
      n = 0;
      while (n < 20) begin
         #1;
         if (cp0_r_data[30]) break;
         cycle();
         n++;
      end
      check("ti_seen", {31'd0, cp0_r_data[30]}, 32'd1);
      check("ti_latency", {31'd0, (n >= 9 && n <= 12)}, 32'd1);
      check("timer_int_req", {31'd0, int_req}, 32'd1);
      rd_check("cause_ti", 5'd13, 32'h4000_8000);
      mtc0(5'd11, 32'd5);
      rd_check("ti_cleared", 5'd13, 32'h0);
      check("timer_int_clear", {31'd0, int_req}, 32'd0);

      // External interrupt line 0 -> IP[10].
      mtc0(5'd12, 32'h0000_0401);
      ext_int = 6'b000001;
      #1;
      check("ext_int_before", {31'd0, int_req}, 32'd0);
      cycle();
      check("ext_int_req", {31'd0, int_req}, 32'd1);
      rd_check("cause_ip10", 5'd13, 32'h0000_0400);
      ext_int = '0;
      cycle();
      check("ext_int_drop", {31'd0, int_req}, 32'd0);

      // Exception in a delay slot, then a nested exception.
      set_exc(32'hBFC0_0100, 1'b1, 5'h04, 32'hDEAD_BEE0, 1'b1);
      cycle();
      clr_exc();
      check("exc_epc_out", epc_out, 32'hBFC0_00FC);
      rd_check("exc_cause", 5'd13, 32'h8000_0010);
      rd_check("exc_status", 5'd12, 32'h0040_0403);
      rd_check("exc_badvaddr", 5'd8, 32'hDEAD_BEE0);
      check("exc_int_masked", {31'd0, int_req}, 32'd0);
      set_exc(32'h8000_0000, 1'b0, 5'h0c, 32'h1234_5678, 1'b0);
      cycle();
      clr_exc();
      check("nested_epc", epc_out, 32'hBFC0_00FC);
      rd_check("nested_cause", 5'd13, 32'h8000_0030);
      rd_check("nested_badvaddr", 5'd8, 32'hDEAD_BEE0);

      // ERET, then exception beats a same-cycle Status write.
      eret = 1'b1;
      cycle();
      eret = 1'b0;
      rd_check("eret_status", 5'd12, 32'h0040_0401);
      set_exc(32'h0000_0100, 1'b0, 5'h08, 32'h0, 1'b0);
      cp0_w_en = 1'b1; cp0_w_addr = 5'd12; cp0_w_data = 32'h0;
      cycle();
      clr_exc();
      cp0_w_en = 1'b0;
      rd_check("exc_over_mtc0", 5'd12, 32'h0040_0403);
      rd_check("exc_over_cause", 5'd13, 32'h0000_0020);
      check("exc_over_epc", epc_out, 32'h0000_0100);

      // ERET beats a same-cycle EPC write.
      eret = 1'b1;
      cp0_w_en = 1'b1; cp0_w_addr = 5'd14; cp0_w_data = 32'h0000_5554;
      cycle();
      eret = 1'b0;
      cp0_w_en = 1'b0;
      check("eret_over_mtc0", epc_out, 32'h0000_0100);
      rd_check("eret_status2", 5'd12, 32'h0040_0401);

      // Compare write still applies under an exception.
      set_exc(32'h0000_0200, 1'b0, 5'h0a, 32'h0, 1'b0);
      cp0_w_en = 1'b1; cp0_w_addr = 5'd11; cp0_w_data = 32'h0000_0077;
      cycle();
      clr_exc();
      cp0_w_en = 1'b0;
      rd_check("compare_under_exc", 5'd11, 32'h0000_0077);

      // Reset overrides concurrent write and exception.
      rst = 1'b1;
      set_exc(32'h0000_0300, 1'b0, 5'h04, 32'h5, 1'b1);
      cp0_w_en = 1'b1; cp0_w_addr = 5'd14; cp0_w_data = 32'hAAAA_AAA8;
      cycle();
      clr_exc();
      cp0_w_en = 1'b0;
      rst = 1'b0;
      rd_check("rst_over_status", 5'd12, 32'h0040_0000);
      rd_check("rst_over_badvaddr", 5'd8, 32'h0);
      check("rst_over_epc", epc_out, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
